// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore coordinator: core-id width helper and control opcodes.
package multicore_pkg;

    localparam logic CTL_PAUSE  = 1'b0;
    localparam logic CTL_RESUME = 1'b1;

    // Width of a core index; never below 1 so a 1-core slice still has a legal vector.
    function automatic int cid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant goes to the first requester at or after the pointer, zero-latency.
// The pointer moves past the winner on every granted cycle and holds when nobody requests.
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int IW = cid_width(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] win;
    logic [IW-1:0] idx_w;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = ptr_q;
        idx   = 0;
        idx_w = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = idx[IW-1:0];
            if (!found && req[idx_w]) begin
                found        = 1'b1;
                win          = idx_w;
                grant[idx_w] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/multicore_ctrl.sv
// Multicore coordinator: per-core run/pause state with start-PC handoff, round-robin shared
// memory port arbitration, stall generation and a sticky global halt.
module multicore_ctrl
    import multicore_pkg::*;
#(
    parameter int             NCORES   = 4,
    parameter int             PCW      = 16,
    parameter logic [PCW-1:0] RESET_PC = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NCORES-1:0]                    ctl_valid,
    input  logic [NCORES-1:0]                    ctl_resume,
    input  logic [NCORES*cid_width(NCORES)-1:0]  ctl_target,
    input  logic [NCORES*PCW-1:0]                ctl_pc,
    output logic [NCORES-1:0]                    ctl_ack,
    input  logic [NCORES-1:0]                    wr_req,
    input  logic [NCORES-1:0]                    rd_req,
    output logic [NCORES-1:0]                    wr_grant,
    output logic [NCORES-1:0]                    rd_grant,
    input  logic [NCORES-1:0]                    halted,
    output logic [NCORES-1:0]                    running,
    output logic [NCORES-1:0]                    stall,
    output logic [NCORES-1:0]                    start_valid,
    output logic [NCORES*PCW-1:0]                start_pc,
    output logic                                 all_halted
);

    localparam int CIDW = cid_width(NCORES);

    logic [NCORES-1:0] running_q, running_d;
    logic [NCORES-1:0] start_valid_q, start_valid_d;
    logic [PCW-1:0]    start_pc_q [NCORES];
    logic [PCW-1:0]    start_pc_d [NCORES];
    logic              boot_done_q;
    logic              all_halted_q, all_halted_d;

    logic [NCORES-1:0] eligible;
    logic [NCORES-1:0] ack;
    logic [NCORES-1:0] wr_arb_req, rd_arb_req;
    logic [CIDW-1:0]   tgt    [NCORES];
    logic [PCW-1:0]    req_pc [NCORES];

    for (genvar g = 0; g < NCORES; g++) begin : g_unpack
        assign tgt[g]                  = ctl_target[g*CIDW +: CIDW];
        assign req_pc[g]               = ctl_pc[g*PCW +: PCW];
        assign start_pc[g*PCW +: PCW]  = start_pc_q[g];
    end

    // Lowest-index eligible requester per target wins; losers see no ack and must hold.
    always_comb begin
        eligible = ctl_valid & running_q & ~halted;
        ack      = '0;
        for (int i = 0; i < NCORES; i++) begin
            ack[i] = eligible[i];
            for (int j = 0; j < i; j++) begin
                if (eligible[j] && (tgt[j] == tgt[i])) begin
                    ack[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        running_d     = running_q;
        start_valid_d = '0;
        for (int i = 0; i < NCORES; i++) begin
            start_pc_d[i] = start_pc_q[i];
        end
        for (int i = 0; i < NCORES; i++) begin
            if (ack[i] && (int'(tgt[i]) < NCORES)) begin
                if (ctl_resume[i] == CTL_RESUME) begin
                    // Resuming a core that is already running is acked but changes nothing.
                    if (!running_q[tgt[i]]) begin
                        running_d[tgt[i]]     = 1'b1;
                        start_valid_d[tgt[i]] = 1'b1;
                        start_pc_d[tgt[i]]    = req_pc[i];
                    end
                end else begin
                    running_d[tgt[i]] = 1'b0;
                end
            end
        end
        if (!boot_done_q) begin
            start_valid_d[0] = 1'b1;
            start_pc_d[0]    = RESET_PC;
        end
        all_halted_d = all_halted_q | (boot_done_q & (&(halted | ~running_q)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q     <= NCORES'(1);
            start_valid_q <= '0;
            boot_done_q   <= 1'b0;
            all_halted_q  <= 1'b0;
            for (int i = 0; i < NCORES; i++) begin
                start_pc_q[i] <= '0;
            end
        end else begin
            running_q     <= running_d;
            start_valid_q <= start_valid_d;
            boot_done_q   <= 1'b1;
            all_halted_q  <= all_halted_d;
            for (int i = 0; i < NCORES; i++) begin
                start_pc_q[i] <= start_pc_d[i];
            end
        end
    end

    assign wr_arb_req = wr_req & running_q & ~halted;
    assign rd_arb_req = rd_req & running_q & ~halted;

    rr_arbiter #(.N(NCORES)) u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_arb_req),
        .grant (wr_grant)
    );

    rr_arbiter #(.N(NCORES)) u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_arb_req),
        .grant (rd_grant)
    );

    assign stall       = ~running_q | (wr_req & ~wr_grant) | (rd_req & ~rd_grant);
    assign ctl_ack     = ack;
    assign running     = running_q;
    assign start_valid = start_valid_q;
    assign all_halted  = all_halted_q;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Directed bench for multicore_ctrl; expectations are queued per sample cycle and checked by a monitor.
module tb_multicore_ctrl;

    localparam int NC  = 4;
    localparam int PCW = 16;
    localparam int CW  = 2;

    localparam int F_RUN   = 0;
    localparam int F_SV    = 1;
    localparam int F_ACK   = 2;
    localparam int F_WRG   = 3;
    localparam int F_RDG   = 4;
    localparam int F_STALL = 5;
    localparam int F_AH    = 6;
    localparam int F_PC    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     ctl_valid, ctl_resume, ctl_ack;
    logic [NC*CW-1:0]  ctl_target;
    logic [NC*PCW-1:0] ctl_pc;
    logic [NC-1:0]     wr_req, rd_req, wr_grant, rd_grant;
    logic [NC-1:0]     halted, running, stall, start_valid;
    logic [NC*PCW-1:0] start_pc;
    logic              all_halted;

    multicore_ctrl #(.NCORES(NC), .PCW(PCW), .RESET_PC(16'h0040)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctl_valid   (ctl_valid),
        .ctl_resume  (ctl_resume),
        .ctl_target  (ctl_target),
        .ctl_pc      (ctl_pc),
        .ctl_ack     (ctl_ack),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_grant    (wr_grant),
        .rd_grant    (rd_grant),
        .halted      (halted),
        .running     (running),
        .stall       (stall),
        .start_valid (start_valid),
        .start_pc    (start_pc),
        .all_halted  (all_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        int          fld;
        int          core;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   neg_cnt = 0;
    int   nx      = 0;
    int   tests   = 0;
    int   fails   = 0;

    function automatic string fname(input int f);
        case (f)
            F_RUN:   return "running";
            F_SV:    return "start_valid";
            F_ACK:   return "ctl_ack";
            F_WRG:   return "wr_grant";
            F_RDG:   return "rd_grant";
            F_STALL: return "stall";
            F_AH:    return "all_halted";
            default: return "start_pc";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int f, input int c);
        case (f)
            F_RUN:   return 32'(running);
            F_SV:    return 32'(start_valid);
            F_ACK:   return 32'(ctl_ack);
            F_WRG:   return 32'(wr_grant);
            F_RDG:   return 32'(rd_grant);
            F_STALL: return 32'(stall);
            F_AH:    return 32'(all_halted);
            default: return 32'(start_pc[c*PCW +: PCW]);
        endcase
    endfunction

    // Monitor: every expectation stamped for this sample cycle is popped and compared.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        neg_cnt = neg_cnt + 1;
        while (sb.size() > 0 && sb[0].at <= neg_cnt) begin
            e     = sb.pop_front();
            act   = actual(e.fld, e.core);
            tests = tests + 1;
            if (e.at != neg_cnt || act !== e.exp) begin
                fails = fails + 1;
                $display("FAIL %s[%0d] cycle %0d: got %h, expected %h (sampled at %0d)",
                         fname(e.fld), e.core, e.at, act, e.exp, neg_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        nx = neg_cnt + 1;
    endtask

    task automatic expect_v(input int f, input int c, input logic [31:0] v);
        exp_t e;
        e.at   = nx;
        e.fld  = f;
        e.core = c;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic ctl(input int i, input logic res, input int t, input logic [15:0] pc);
        ctl_valid[i]            = 1'b1;
        ctl_resume[i]           = res;
        ctl_target[i*CW +: CW]  = CW'(t);
        ctl_pc[i*PCW +: PCW]    = pc;
    endtask

    initial begin
        rst        = 1'b1;
        ctl_valid  = '0;
        ctl_resume = '0;
        ctl_target = '0;
        ctl_pc     = '0;
        wr_req     = '0;
        rd_req     = '0;
        halted     = '0;

        // Reset state
        repeat (3) begin
            step();
            expect_v(F_RUN, 0, 4'b0001);
            expect_v(F_SV, 0, 4'b0000);
            expect_v(F_AH, 0, 1'b0);
            expect_v(F_PC, 0, 16'h0000);
            expect_v(F_STALL, 0, 4'b1110);
            expect_v(F_WRG, 0, 4'b0000);
        end

        // Release, then the one-shot boot pulse
        step(); rst = 1'b0;
        expect_v(F_RUN, 0, 4'b0001); expect_v(F_SV, 0, 4'b0000);
        step();
        expect_v(F_SV, 0, 4'b0001); expect_v(F_PC, 0, 16'h0040); expect_v(F_RUN, 0, 4'b0001);

        // Core 0 resumes core 2 at 0x1234
        step(); ctl(0, 1'b1, 2, 16'h1234);
        expect_v(F_SV, 0, 4'b0000); expect_v(F_ACK, 0, 4'b0001); expect_v(F_RUN, 0, 4'b0001);
        step(); ctl_valid = '0;
        expect_v(F_RUN, 0, 4'b0101); expect_v(F_SV, 0, 4'b0100);
        expect_v(F_PC, 2, 16'h1234); expect_v(F_ACK, 0, 4'b0000);
        step();
        expect_v(F_SV, 0, 4'b0000); expect_v(F_RUN, 0, 4'b0101);

        // Cores 0 and 2 contend for the write port
        for (int k = 0; k < 4; k++) begin
            step(); wr_req = 4'b0101;
            expect_v(F_WRG, 0, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            expect_v(F_STALL, 0, (k % 2 == 0) ? 4'b1110 : 4'b1011);
        end

        // Write pointer now 3 (wraps to core 0); read pointer still 0
        step(); wr_req = 4'b0001; rd_req = 4'b0101;
        expect_v(F_WRG, 0, 4'b0001); expect_v(F_RDG, 0, 4'b0001); expect_v(F_STALL, 0, 4'b1110);
        step(); wr_req = 4'b0000;
        expect_v(F_RDG, 0, 4'b0100); expect_v(F_STALL, 0, 4'b1011);

        // Bring core 1 up
        step(); rd_req = '0; ctl(0, 1'b1, 1, 16'h0ABC);
        expect_v(F_ACK, 0, 4'b0001);
        step(); ctl_valid = '0;
        expect_v(F_RUN, 0, 4'b0111); expect_v(F_SV, 0, 4'b0010); expect_v(F_PC, 1, 16'h0ABC);

        // Same-cycle pause (core 0) and resume (core 2) of core 1
        step(); ctl(0, 1'b0, 1, 16'h0000); ctl(2, 1'b1, 1, 16'h5555);
        expect_v(F_ACK, 0, 4'b0001); expect_v(F_SV, 0, 4'b0000);
        step(); ctl_valid = '0;
        expect_v(F_RUN, 0, 4'b0101); expect_v(F_STALL, 0, 4'b1010);
        expect_v(F_SV, 0, 4'b0000); expect_v(F_PC, 1, 16'h0ABC);

        // Core 2 pauses itself while holding a write grant
        step(); ctl(2, 1'b0, 2, 16'h0000); wr_req = 4'b0100;
        expect_v(F_ACK, 0, 4'b0100); expect_v(F_WRG, 0, 4'b0100); expect_v(F_STALL, 0, 4'b1010);
        step(); ctl_valid = '0; wr_req = '0;
        expect_v(F_RUN, 0, 4'b0001); expect_v(F_WRG, 0, 4'b0000); expect_v(F_STALL, 0, 4'b1110);

        // Resume of an already-running core: ack only
        step(); ctl(0, 1'b1, 0, 16'h9999);
        expect_v(F_ACK, 0, 4'b0001);
        step(); ctl_valid = '0;
        expect_v(F_SV, 0, 4'b0000); expect_v(F_RUN, 0, 4'b0001); expect_v(F_PC, 0, 16'h0040);

        // A paused core's request is ignored
        step(); ctl(3, 1'b0, 0, 16'h0000);
        expect_v(F_ACK, 0, 4'b0000);
        step(); ctl_valid = '0;
        expect_v(F_RUN, 0, 4'b0001);

        // Reset lands between an ack and its capture edge
        step(); ctl(0, 1'b1, 3, 16'h7777);
        expect_v(F_ACK, 0, 4'b0001);
        @(negedge clk); #1; rst = 1'b1; ctl_valid = '0;
        step(); rst = 1'b0;
        expect_v(F_RUN, 0, 4'b0001); expect_v(F_SV, 0, 4'b0000);
        step();
        expect_v(F_SV, 0, 4'b0001); expect_v(F_PC, 0, 16'h0040);
        expect_v(F_PC, 3, 16'h0000); expect_v(F_RUN, 0, 4'b0001);
        step();
        expect_v(F_SV, 0, 4'b0000); expect_v(F_RUN, 0, 4'b0001);

        // Sole running core halts
        step(); halted = 4'b0001;
        expect_v(F_AH, 0, 1'b0); expect_v(F_STALL, 0, 4'b1110);
        step(); halted = 4'b0000;
        expect_v(F_AH, 0, 1'b1);
        step();
        expect_v(F_AH, 0, 1'b1); expect_v(F_RUN, 0, 4'b0001);

        repeat (3) @(negedge clk);
        #1;
        tests = tests + 1;
        if (sb.size() != 0) begin
            fails = fails + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicore_ctrl.md
# multicore_ctrl

Parametrised multicore coordinator that sits at the top level between NCORES cores and the shared memory. It owns each core's run/pause state and applies inter-core pause/resume requests, including a start-PC handoff. It arbitrates the single shared memory write port and the single shared memory read port with round-robin fairness, and raises a global halt once no core can make progress.

## Interface
- NCORES, 4: number of cores; 2..16.
- PCW, 16: program-counter width.
- RESET_PC, 0: start PC given to core 0 after reset.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctl_valid  in  NCORES  core i presents a control request.
- ctl_resume  in  NCORES  1 = resume target, 0 = pause target.
- ctl_target  in  NCORES*CIDW  target core id per requester (CIDW = $clog2(NCORES)).
- ctl_pc  in  NCORES*PCW  start PC for a resume.
- ctl_ack  out  NCORES  request accepted this cycle (combinational).
- wr_req  in  NCORES  core wants the write port this cycle.
- rd_req  in  NCORES  core wants the read port this cycle.
- wr_grant  out  NCORES  one-hot or zero; write-port owner.
- rd_grant  out  NCORES  one-hot or zero; read-port owner.
- halted  in  NCORES  core has executed halt.
- running  out  NCORES  registered run state.
- stall  out  NCORES  core must hold its pipeline this cycle.
- start_valid  out  NCORES  one-cycle pulse; core loads start_pc.
- start_pc  out  NCORES*PCW  PC accompanying start_valid.
- all_halted  out  1  sticky global halt.

## Operation
- Reset values: running = 0 except bit 0 = 1; start_valid = 0; start_pc = 0; all_halted = 0; both round-robin pointers = 0.
- Boot: in the first cycle after rst deasserts, start_valid[0] = 1 and start_pc[0] = RESET_PC. This is a one-shot, driven by a boot flag.
- Control requests:
  - A request from core i is eligible only if running[i] = 1 and halted[i] = 0.
  - For each target, the lowest-index eligible requester wins.
  - The winner gets ctl_ack = 1. Losers get ack = 0 and must hold their request.
  - Pause: running[t] <= 0. Self-pause is legal.
  - Resume of a paused target: running[t] <= 1, plus start_valid[t] and start_pc[t] = ctl_pc of the winner, both on the next cycle.
  - Resume of an already-running target: acked, no state change, no pulse.
- Memory arbitration uses two independent rr_arbiter instances.
  - Request vector = req & running & ~halted.
  - The grant goes to the first requester at or after the pointer, wrapping modulo NCORES.
  - On a grant, the pointer <= winner + 1 (mod NCORES). With no requests the pointer is unchanged.
- stall[i] = ~running[i] | (wr_req[i] & ~wr_grant[i]) | (rd_req[i] & ~rd_grant[i]).
- A core that requests both ports stalls unless it receives both grants. Any grant it does receive is still consumed and still advances that arbiter's pointer.
- all_halted is set when, for every i, (halted[i] | ~running[i]) holds for one cycle. It is checked only after the boot cycle. It is cleared only by rst.

## Timing
- ctl_ack, wr_grant, rd_grant and stall are combinational from the same-cycle inputs and registered state.
- running changes one cycle after an acked request. start_valid is asserted in that same cycle, for exactly one cycle.
- A paused core sees stall = 1 starting in the cycle after the ack.
- Round-robin pointers update on the grant edge.
- Same-cycle pause and resume to the same target: the lower-index requester wins and the other is not acked.
- A core that both pauses itself and requests memory in the same cycle: the memory grant is still honoured that cycle.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous). Any pending start pulse is dropped. The boot pulse repeats after release.
- all_halted rises one cycle after the condition holds.

## Structure
- Package multicore_pkg:
  - CIDW function ($clog2 wrapper).
  - Control-opcode localparams (PAUSE = 0, RESUME = 1).
- Sub-module rr_arbiter #(N):
  - Inputs: clk, rst, req[N].
  - Output: grant[N], one-hot.
  - Contains the pointer register.
  - Instantiated twice: write port and read port.
- Top-level control: per-target priority select via a for-loop; registered running, start_valid and start_pc vectors; boot flag; all_halted flag.

## Test plan
- Reset release, NCORES = 4, RESET_PC = 0x0040 -> running = 0001, start_valid = 0001 with start_pc[0] = 0x0040 for one cycle, then 0.
- Core 0 resumes core 2 with ctl_pc = 0x1234 -> ctl_ack[0] = 1 in that cycle; next cycle running = 0101, start_valid[2] = 1, start_pc[2] = 0x1234.
- Cores 0 and 2 both hold wr_req = 1 for 4 cycles with the pointer at 0 -> wr_grant = 0001, 0100, 0001, 0100; the non-granted core has stall = 1 in each cycle.
- Same cycle: core 0 pauses core 1 and core 2 resumes core 1 (core 1 running) -> ack = 0001 only; next cycle running[1] = 0, stall[1] = 1.
- Core 0 (sole running core) asserts halted = 1 -> all_halted = 1 one cycle later and stays 1 until rst.
- rst pulsed while a resume ack is in flight -> no start_valid for the target; only the boot pulse to core 0 follows release.
